// File: rtl/pc_branch_unit_pkg.sv
// Shared definitions for the PC / branch unit: condition codes, flag bit
// positions and the run/fault state enumeration.
package pc_branch_unit_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_e;

endpackage

// File: rtl/pc_branch_unit_if.sv
// Control-word and PC/flag bundle between the control path and the PC unit.
// master = control-path side, slave = pc_branch_unit.
interface pc_branch_unit_if #(parameter int XLEN = 32);
  logic            instr_valid;
  logic            stall;
  logic [3:0]      nzcv_write;
  logic [3:0]      alu_nzcv;
  logic [3:0]      cond;
  logic            bsel;
  logic            c_branch;
  logic            r_branch;
  logic [XLEN-1:0] br_imm;
  logic [XLEN-1:0] rm_val;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic            taken;
  logic [3:0]      nzcv;
  logic            fault;

  modport master (
    output instr_valid, stall, nzcv_write, alu_nzcv, cond, bsel,
           c_branch, r_branch, br_imm, rm_val,
    input  pc, pc_next, taken, nzcv, fault
  );

  modport slave (
    input  instr_valid, stall, nzcv_write, alu_nzcv, cond, bsel,
           c_branch, r_branch, br_imm, rm_val,
    output pc, pc_next, taken, nzcv, fault
  );
endinterface

// File: rtl/pc_branch_unit_cond_eval.sv
// Combinational ARM condition-code evaluator: COND + NZCV -> pass.
// Kept standalone so a predicated-execution stage can reuse it.
module pc_branch_unit_cond_eval
  import pc_branch_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[N_BIT];
  assign z = nzcv[Z_BIT];
  assign c = nzcv[C_BIT];
  assign v = nzcv[V_BIT];

  // Decode the condition code against the supplied flags.
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Architectural PC and NZCV owner for the single-cycle core. Selects the next
// PC (sequential / PC-relative / register), masks flag writes and latches a
// sticky alignment fault that freezes PC and flags until reset.
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_INC   = 4
) (
  input logic             clk,
  input logic             rst_n,
  pc_branch_unit_if.slave bus
);

  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(PC_INC);
  localparam logic [XLEN-1:0] MODE_BIT = XLEN'(1);

  state_e          state;
  logic [XLEN-1:0] pc_q;
  logic [3:0]      nzcv_q;
  logic            fault_q;

  logic            pass;
  logic            taken;
  logic [XLEN-1:0] tgt;
  logic            misaligned;
  logic            upd;
  logic [XLEN-1:0] pc_next;

  pc_branch_unit_cond_eval u_cond_eval (
    .cond (bus.cond),
    .nzcv (nzcv_q),
    .pass (pass)
  );

  // Unconditional and register branches short-circuit COND, so an undefined
  // COND on those paths never reaches taken.
  assign taken = bus.instr_valid & bus.bsel
               & (bus.r_branch | ~bus.c_branch | pass);

  // BX drops the mode bit; relative targets wrap modulo 2^XLEN.
  assign tgt = bus.r_branch ? (bus.rm_val & ~MODE_BIT)
                            : (pc_q + PC_STEP + bus.br_imm);

  // Register targets already have bit 0 cleared, so one word-alignment test
  // covers both branch kinds.
  assign misaligned = taken & (tgt[1:0] != 2'b00);

  assign upd = bus.instr_valid & ~bus.stall & (state == RUN);

  // Next-PC priority: hold, then faulting branch holds, then target, then +PC_INC.
  always_comb begin
    pc_next = pc_q + PC_STEP;
    if ((state == FAULT) || bus.stall || !bus.instr_valid) begin
      pc_next = pc_q;
    end else if (misaligned) begin
      pc_next = pc_q;
    end else if (taken) begin
      pc_next = tgt;
    end
  end

  // Run/fault FSM with PC, flag and fault registers updated together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      pc_q    <= RESET_PC;
      nzcv_q  <= 4'b0000;
      fault_q <= 1'b0;
    end else if (upd) begin
      pc_q   <= pc_next;
      nzcv_q <= (nzcv_q & ~bus.nzcv_write) | (bus.alu_nzcv & bus.nzcv_write);
      if (misaligned) begin
        state   <= FAULT;
        fault_q <= 1'b1;
      end
    end
  end

  assign bus.pc      = pc_q;
  assign bus.pc_next = pc_next;
  assign bus.taken   = taken;
  assign bus.nzcv    = nzcv_q;
  assign bus.fault   = fault_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit with a per-cycle reference model.
module tb_pc_branch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  pc_branch_unit_if #(.XLEN(32)) bus ();

  pc_branch_unit #(
    .XLEN     (32),
    .RESET_PC (RST_PC),
    .PC_INC   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ARM scheme: cond[3:1] picks a base predicate, cond[0] inverts it (except 111x).
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = (n == v) && !z;
      default: base = 1'b1;
    endcase
    if (c[3:1] == 3'd7) return (c == 4'hE);
    return base ^ c[0];
  endfunction

  // Reference model state
  logic [31:0] m_pc, n_pc;
  logic [3:0]  m_nzcv, n_nzcv;
  logic        m_fault, n_fault;

  // Per-cycle compare against the model, then advance the model on the edge.
  always begin
    logic        e_taken, e_bad;
    logic [31:0] e_tgt, e_next;
    @(negedge clk);
    if (!rst_n) begin
      m_pc = RST_PC; m_nzcv = 4'h0; m_fault = 1'b0;
    end
    e_taken = bus.instr_valid && bus.bsel &&
              (bus.r_branch || !bus.c_branch || cond_ok(bus.cond, m_nzcv));
    e_tgt   = bus.r_branch ? {bus.rm_val[31:1], 1'b0} : m_pc + 32'd4 + bus.br_imm;
    e_bad   = e_taken && (e_tgt % 4 != 0);
    if (m_fault || bus.stall || !bus.instr_valid || e_bad) e_next = m_pc;
    else if (e_taken) e_next = e_tgt;
    else e_next = m_pc + 32'd4;
    chk("pc", bus.pc, m_pc);
    chk("nzcv", {28'd0, bus.nzcv}, {28'd0, m_nzcv});
    chk("fault", {31'd0, bus.fault}, {31'd0, m_fault});
    chk("taken", {31'd0, bus.taken}, {31'd0, e_taken});
    chk("pc_next", bus.pc_next, e_next);
    n_pc = m_pc; n_nzcv = m_nzcv; n_fault = m_fault;
    if (bus.instr_valid && !bus.stall && !m_fault) begin
      n_pc = e_next;
      for (int i = 0; i < 4; i++)
        if (bus.nzcv_write[i]) n_nzcv[i] = bus.alu_nzcv[i];
      if (e_bad) n_fault = 1'b1;
    end
    @(posedge clk);
    if (rst_n) begin
      m_pc = n_pc; m_nzcv = n_nzcv; m_fault = n_fault;
    end
  end

  task automatic drive(input logic v, input logic st, input logic [3:0] w,
                       input logic [3:0] alu, input logic [3:0] cnd, input logic b,
                       input logic cb, input logic rb, input logic [31:0] imm,
                       input logic [31:0] rm);
    bus.instr_valid = v;  bus.stall = st;   bus.nzcv_write = w; bus.alu_nzcv = alu;
    bus.cond = cnd;       bus.bsel = b;     bus.c_branch = cb;  bus.r_branch = rb;
    bus.br_imm = imm;     bus.rm_val = rm;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0; bad = 0;
    m_pc = RST_PC; m_nzcv = 4'h0; m_fault = 1'b0;
    rst_n = 1'b0;
    bus.instr_valid = 1'b0; bus.stall = 1'b0; bus.nzcv_write = 4'h0; bus.alu_nzcv = 4'h0;
    bus.cond = 4'h0; bus.bsel = 1'b0; bus.c_branch = 1'b0; bus.r_branch = 1'b0;
    bus.br_imm = 32'h0; bus.rm_val = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", bus.pc, 32'h100);
    rst_n = 1'b1;

    // sequential fetch
    repeat (3) drive(1, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 32'h0, 32'h0);
    chk("seq_pc", bus.pc, 32'h10C);
    chk("seq_nzcv", {28'd0, bus.nzcv}, 32'h0);

    // masked flag writes
    drive(1, 0, 4'b0100, 4'b1111, 4'h0, 0, 0, 0, 32'h0, 32'h0);
    chk("flag_w1", {28'd0, bus.nzcv}, 32'h4);
    drive(1, 0, 4'b1001, 4'b1001, 4'h0, 0, 0, 0, 32'h0, 32'h0);
    chk("flag_w2", {28'd0, bus.nzcv}, 32'hD);

    // EQ / NE from 0x200 with Z=1
    drive(1, 0, 4'h0, 4'h0, 4'h0, 1, 0, 1, 32'h0, 32'h200);
    chk("bx_200", bus.pc, 32'h200);
    drive(1, 0, 4'h0, 4'h0, 4'h0, 1, 1, 0, 32'h10, 32'h0);
    chk("beq_taken", bus.pc, 32'h214);
    drive(1, 0, 4'h0, 4'h0, 4'h0, 1, 0, 1, 32'h0, 32'h200);
    drive(1, 0, 4'h0, 4'h0, 4'h1, 1, 1, 0, 32'h10, 32'h0);
    chk("bne_not_taken", bus.pc, 32'h204);

    // stall holds a taken branch and its flag write
    repeat (2) drive(1, 1, 4'hF, 4'h0, 4'hE, 1, 1, 0, 32'h20, 32'h0);
    chk("stall_pc", bus.pc, 32'h204);
    chk("stall_nzcv", {28'd0, bus.nzcv}, 32'hD);
    drive(1, 0, 4'hF, 4'h0, 4'hE, 1, 1, 0, 32'h20, 32'h0);
    chk("unstall_pc", bus.pc, 32'h228);
    chk("unstall_nzcv", {28'd0, bus.nzcv}, 32'h0);

    // NV, LT (N=1 V=0), GT (Z=0 N=V=1)
    drive(1, 0, 4'hF, 4'b1000, 4'h0, 0, 0, 0, 32'h0, 32'h0);
    drive(1, 0, 4'h0, 4'h0, 4'hF, 1, 1, 0, 32'h40, 32'h0);
    chk("nv_pc", bus.pc, 32'h230);
    drive(1, 0, 4'h0, 4'h0, 4'hB, 1, 1, 0, 32'h40, 32'h0);
    chk("lt_pc", bus.pc, 32'h274);
    drive(1, 0, 4'hF, 4'b1001, 4'h0, 0, 0, 0, 32'h0, 32'h0);
    drive(1, 0, 4'h0, 4'h0, 4'hC, 1, 1, 0, 32'hFFFF_FFF8, 32'h0);
    chk("gt_back_pc", bus.pc, 32'h274);

    // BX mode bit, then misaligned BX faults; flags still written that edge
    drive(1, 0, 4'h0, 4'h0, 4'h0, 1, 0, 1, 32'h0, 32'h301);
    chk("bx_301", bus.pc, 32'h300);
    drive(1, 0, 4'hF, 4'b0110, 4'h0, 1, 0, 1, 32'h0, 32'h303);
    chk("bx_fault", {31'd0, bus.fault}, 32'h1);
    chk("bx_fault_pc", bus.pc, 32'h300);
    chk("bx_fault_nzcv", {28'd0, bus.nzcv}, 32'h6);
    repeat (3) drive(1, 0, 4'hF, 4'hF, 4'h0, 0, 0, 0, 32'h0, 32'h0);
    drive(1, 0, 4'hF, 4'hF, 4'hE, 1, 1, 0, 32'h8, 32'h0);
    chk("frozen_pc", bus.pc, 32'h300);
    chk("frozen_nzcv", {28'd0, bus.nzcv}, 32'h6);

    // asynchronous reset clears the fault
    bus.instr_valid = 1'b0; bus.bsel = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("async_rst_pc", bus.pc, 32'h100);
    chk("async_rst_fault", {31'd0, bus.fault}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 32'h0, 32'h0);
    chk("post_rst_pc", bus.pc, 32'h104);

    // misaligned relative target (0x104+4+2) faults and holds PC
    drive(1, 0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 32'h2, 32'h0);
    chk("rel_fault", {31'd0, bus.fault}, 32'h1);
    chk("rel_fault_pc", bus.pc, 32'h104);
    drive(1, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 32'h0, 32'h0);
    chk("rel_frozen_pc", bus.pc, 32'h104);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Consumes the control word from the control-path generator and owns the architectural PC and the NZCV flag register.
- Each cycle it does four things:
  - applies the per-bit NZCVWRITE mask to the ALU flags;
  - evaluates the 4-bit COND code against the registered flags;
  - selects the next PC from sequential, PC-relative or register targets;
  - latches a sticky alignment fault.
- Feeds the instruction-memory address and the fault line of the single-cycle core.

Parameters:
- XLEN, 32, width of PC and target datapath.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_INC, 4, sequential increment and PC-relative base offset (bytes).

Ports:
- CLK  in  1  core clock.
- RSTN  in  1  reset; asynchronous assert, active-low.
- INSTR_VALID  in  1  current control word is valid.
- STALL  in  1  hold all state this cycle.
- NZCVWRITE  in  4  per-flag write enable, bit3=N bit2=Z bit1=C bit0=V.
- ALU_NZCV  in  4  flags produced by the ALU this cycle, same bit order.
- COND  in  4  condition code for C_BRANCH.
- BSEL  in  1  instruction is a branch.
- C_BRANCH  in  1  branch is conditional on COND.
- R_BRANCH  in  1  target comes from the register (BX).
- BR_IMM  in  XLEN  sign-extended byte offset for relative branches.
- RM_VAL  in  XLEN  register operand for BX.
- PC  out  XLEN  current PC (registered).
- PC_NEXT  out  XLEN  combinational next PC.
- TAKEN  out  1  combinational: branch taken this cycle.
- NZCV  out  4  registered flags.
- FAULT  out  1  sticky alignment fault.

Behaviour:
- Reset (RSTN=0, asynchronous): PC=RESET_PC, NZCV=4'b0000, FAULT=0, state=RUN.
  - TAKEN and PC_NEXT follow the combinational rules using the reset register values.
- Update enable: upd = INSTR_VALID & ~STALL & (state==RUN). All registers hold when upd=0.
- Flags:
  - On upd, for each bit i: NZCV[i] <= NZCVWRITE[i] ? ALU_NZCV[i] : NZCV[i].
  - Flags written by an instruction are not visible to its own COND, which uses registered NZCV only.
- Condition pass, ARM encoding:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 never.
- Taken: TAKEN = INSTR_VALID & BSEL & (R_BRANCH | ~C_BRANCH | pass). X on COND when C_BRANCH=0 must not propagate to TAKEN.
- Target:
  - R_BRANCH=1: tgt = {RM_VAL[XLEN-1:1],1'b0}; bit0 is the mode bit and is ignored.
  - Otherwise: tgt = PC + PC_INC + BR_IMM, modulo 2^XLEN (wrap-around allowed, no fault).
- Alignment: misaligned = TAKEN & (tgt[1] != 0), or for relative branches tgt[1:0] != 0.
- PC_NEXT:
  - state==FAULT or STALL or ~INSTR_VALID: PC.
  - misaligned: PC.
  - TAKEN: tgt.
  - Else: PC + PC_INC.
- On upd, PC <= PC_NEXT.
- FSM, states RUN and FAULT:
  - RUN -> FAULT on upd & misaligned; FAULT <= 1 on the same edge.
  - Flags still update on that edge.
  - FAULT is absorbing; only RSTN exits it.
  - In FAULT, PC and NZCV are frozen and TAKEN is still reported combinationally.
- Simultaneous events:
  - STALL dominates everything; no fault is latched while stalled.
  - A reset asserted mid-cycle overrides any pending update.

Decomposition:
- Shared package holds:
  - COND code constants (COND_EQ..COND_NV);
  - NZCV bit-index constants (N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0);
  - state enumeration RUN/FAULT.
- One natural sub-module, cond_eval: purely combinational, COND + NZCV -> pass. It is reusable by a future predicated-execution stage.

Test Plan:
- Reset release with RESET_PC=0x100, INSTR_VALID=1, BSEL=0 for 3 cycles -> PC = 0x100, 0x104, 0x108, 0x10C; NZCV=0.
- NZCVWRITE=4'b0100, ALU_NZCV=4'b1111 -> NZCV=4'b0100. Next cycle NZCVWRITE=4'b1001, ALU_NZCV=4'b1001 -> NZCV=4'b1101.
- Z=1, PC=0x200, BSEL=1, C_BRANCH=1, COND=0000, BR_IMM=0x10 -> TAKEN=1, next PC=0x214. Same with COND=0001 -> TAKEN=0, PC=0x204.
- BX with R_BRANCH=1, RM_VAL=0x0000_0301 -> PC=0x300. Then RM_VAL=0x0000_0303 -> FAULT=1 and PC stays 0x300 for all later cycles until RSTN.
- STALL=1 for 2 cycles while a taken branch is presented -> PC and NZCV unchanged. STALL=0 -> branch retires.
- COND=1111 with C_BRANCH=1 -> never taken. COND=1011 with N=1, V=0 -> taken. COND=1100 with Z=0, N=V=1 -> taken.
